elastic_pipe_buffer: RTL and testbench

//  Parametrised elastic inter-stage pipeline register: successor to the fixed single-entry stage buffer.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_buf_mem.sv | 28 ++
 rtl/elastic_pipe_buffer.sv | 102 ++++++++++
 tb/tb_elastic_pipe_buffer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-buffer definitions: stage payload widths, default depth and a
// constant-foldable ceil(log2) helper used to size counters and pointers.
package pipe_pkg;

  localparam int IF_ID_W       = 64;
  localparam int ID_EX_W       = 134;
  localparam int EX_MEM_W      = 106;
  localparam int MEM_WB_W      = 58;
  localparam int DEFAULT_DEPTH = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pipe_buf_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module pipe_buf_mem
  import pipe_pkg::*;
#(
  parameter int WIDTH = IF_ID_W,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PW    = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/elastic_pipe_buffer.sv
// Elastic DEPTH-entry inter-stage pipeline buffer with valid/ready handshake, flush and count.
// Optional feature: define ELASTIC_BUF_FALLTHROUGH_EN for a zero-latency bypass when empty.
module elastic_pipe_buffer
  import pipe_pkg::*;
#(
  parameter int WIDTH = IF_ID_W,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        Flush,
  input  logic                        InValid,
  output logic                        InReady,
  input  logic [WIDTH-1:0]            InData,
  output logic                        OutValid,
  input  logic                        OutReady,
  output logic [WIDTH-1:0]            OutData,
  output logic [clog2(DEPTH+1)-1:0]   Count
);

  localparam int CW = clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic             push;
  logic             pop;

  assign empty   = (count_q == '0);
  assign InReady = Rst & ~Flush & (count_q < DEPTH_C);
  assign Count   = count_q;

`ifdef ELASTIC_BUF_FALLTHROUGH_EN
  logic bypass;

  // An empty buffer hands the incoming word straight through; it is only stored if not taken.
  assign bypass   = Rst & empty & InValid & ~Flush;
  assign OutValid = (~Flush & ~empty) | bypass;
  assign OutData  = bypass ? InData : (empty ? '0 : rd_data);
  assign push     = InValid & InReady & ~(bypass & OutReady);
  assign pop      = OutValid & OutReady & ~empty;
`else
  assign OutValid = ~Flush & ~empty;
  assign OutData  = empty ? '0 : rd_data;
  assign push     = InValid & InReady;
  assign pop      = OutValid & OutReady;
`endif

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (Flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  pipe_buf_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk     (Clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (InData),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_elastic_pipe_buffer.sv
// Directed self-checking bench for elastic_pipe_buffer (DEPTH=2 and DEPTH=3 instances),
// with expectations for both settings of ELASTIC_BUF_FALLTHROUGH_EN.
module tb_elastic_pipe_buffer;

  logic        clk;
  logic        rst;
  int          errors;
  int          checks;

  logic        a_flush, a_iv, a_ir, a_ov, a_or;
  logic [63:0] a_din, a_dout;
  logic [1:0]  a_cnt;

  logic        b_flush, b_iv, b_ir, b_ov, b_or;
  logic [15:0] b_din, b_dout;
  logic [1:0]  b_cnt;

  elastic_pipe_buffer #(.WIDTH(64), .DEPTH(2)) dut2 (
    .Clk(clk), .Rst(rst), .Flush(a_flush),
    .InValid(a_iv), .InReady(a_ir), .InData(a_din),
    .OutValid(a_ov), .OutReady(a_or), .OutData(a_dout), .Count(a_cnt)
  );

  elastic_pipe_buffer #(.WIDTH(16), .DEPTH(3)) dut3 (
    .Clk(clk), .Rst(rst), .Flush(b_flush),
    .InValid(b_iv), .InReady(b_ir), .InData(b_din),
    .OutValid(b_ov), .OutReady(b_or), .OutData(b_dout), .Count(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst     = 1'b0;
    a_flush = 1'b0; a_iv = 1'b0; a_or = 1'b0; a_din = '0;
    b_flush = 1'b0; b_iv = 1'b0; b_or = 1'b0; b_din = '0;

    #3;
    check_output("rst_count",    64'(a_cnt), 64'd0);
    check_output("rst_outvalid", 64'(a_ov),  64'd0);
    check_output("rst_inready",  64'(a_ir),  64'd0);
    check_output("rst_outdata",  a_dout,     64'd0);
    tick();
    rst = 1'b1;
    #1;
    check_output("rel_inready", 64'(a_ir), 64'd1);

    // Fill with downstream stalled, then drain in order
    a_iv = 1'b1; a_or = 1'b0; a_din = 64'hA1;
    tick();
    a_din = 64'hB2;
    #1;
    check_output("fill1_count",   64'(a_cnt), 64'd1);
    check_output("fill1_ovalid",  64'(a_ov),  64'd1);
    check_output("fill1_data",    a_dout,     64'hA1);
    tick();
    a_din = 64'hC3;
    #1;
    check_output("fill2_count",   64'(a_cnt), 64'd2);
    check_output("fill2_inready", 64'(a_ir),  64'd0);
    check_output("fill2_data",    a_dout,     64'hA1);
    tick();
    check_output("held_count",    64'(a_cnt), 64'd2);
    a_or = 1'b1;
    #1;
    check_output("drain0_data",   a_dout,     64'hA1);
    check_output("drain0_inrdy",  64'(a_ir),  64'd0);
    tick();
    check_output("drain1_count",  64'(a_cnt), 64'd1);
    check_output("drain1_data",   a_dout,     64'hB2);
    check_output("drain1_inrdy",  64'(a_ir),  64'd1);
    tick();
    check_output("pushpop_count", 64'(a_cnt), 64'd1);
    check_output("drain2_data",   a_dout,     64'hC3);
    a_iv = 1'b0;
    tick();
    check_output("empty_count",   64'(a_cnt), 64'd0);
    check_output("empty_ovalid",  64'(a_ov),  64'd0);
    check_output("empty_data",    a_dout,     64'd0);

    // Flush with two entries held and upstream still offering data
    a_or = 1'b0; a_iv = 1'b1; a_din = 64'h11;
    tick();
    a_din = 64'h22;
    tick();
    check_output("preflush_count", 64'(a_cnt), 64'd2);
    a_din = 64'h33; a_flush = 1'b1;
    #1;
    check_output("flush_inready", 64'(a_ir), 64'd0);
    check_output("flush_ovalid",  64'(a_ov), 64'd0);
    tick();
    a_flush = 1'b0; a_din = 64'h55;
    #1;
    check_output("postflush_count", 64'(a_cnt), 64'd0);
`ifdef ELASTIC_BUF_FALLTHROUGH_EN
    check_output("postflush_ovalid", 64'(a_ov), 64'd1);
`else
    check_output("postflush_ovalid", 64'(a_ov), 64'd0);
`endif
    tick();
    a_iv = 1'b0;
    #1;
    check_output("flush55_count", 64'(a_cnt), 64'd1);
    check_output("flush55_data",  a_dout,     64'h55);
    a_or = 1'b1;
    tick();
    check_output("flush55_drain", 64'(a_cnt), 64'd0);
    a_or = 1'b0;

    // Asynchronous reset in the middle of a cycle with two entries held
    a_iv = 1'b1; a_din = 64'h66;
    tick();
    a_din = 64'h77;
    tick();
    check_output("prerst_count", 64'(a_cnt), 64'd2);
    a_iv = 1'b0;
    rst  = 1'b0;
    #1;
    check_output("midrst_count",   64'(a_cnt), 64'd0);
    check_output("midrst_ovalid",  64'(a_ov),  64'd0);
    check_output("midrst_data",    a_dout,     64'd0);
    check_output("midrst_inready", 64'(a_ir),  64'd0);
    tick();
    rst = 1'b1;
    #1;
    check_output("postrst_inready", 64'(a_ir),  64'd1);
    check_output("postrst_count",   64'(a_cnt), 64'd0);

    // Empty buffer, downstream ready: bypass when enabled, one-cycle latency otherwise
    a_or = 1'b1; a_iv = 1'b1; a_din = 64'h1234;
    #1;
`ifdef ELASTIC_BUF_FALLTHROUGH_EN
    check_output("ft_ovalid", 64'(a_ov),  64'd1);
    check_output("ft_data",   a_dout,     64'h1234);
    check_output("ft_count",  64'(a_cnt), 64'd0);
    tick();
    a_iv = 1'b0;
    #1;
    check_output("ft_after_count",  64'(a_cnt), 64'd0);
    check_output("ft_after_ovalid", 64'(a_ov),  64'd0);
`else
    check_output("ft_ovalid", 64'(a_ov), 64'd0);
    check_output("ft_data",   a_dout,    64'd0);
    tick();
    a_iv = 1'b0;
    #1;
    check_output("ft_after_ovalid", 64'(a_ov),  64'd1);
    check_output("ft_after_data",   a_dout,     64'h1234);
    check_output("ft_after_count",  64'(a_cnt), 64'd1);
    tick();
    check_output("ft_drain_count",  64'(a_cnt), 64'd0);
`endif
    a_or = 1'b0;

    // Continuous streaming through the DEPTH=3 instance; 24 words wrap the pointers many times
    b_iv = 1'b1; b_or = 1'b1;
    for (int i = 0; i < 24; i++) begin
      b_din = 16'h0100 + 16'(i);
      #1;
      check_output("stream_inready", 64'(b_ir), 64'd1);
`ifdef ELASTIC_BUF_FALLTHROUGH_EN
      check_output("stream_ovalid", 64'(b_ov),  64'd1);
      check_output("stream_data",   64'(b_dout), 64'h0100 + 64'(i));
      check_output("stream_count",  64'(b_cnt), 64'd0);
`else
      check_output("stream_ovalid", 64'(b_ov),  (i > 0) ? 64'd1 : 64'd0);
      if (i > 0) begin
        check_output("stream_data", 64'(b_dout), 64'h0100 + 64'(i - 1));
      end
      check_output("stream_count",  64'(b_cnt), (i > 0) ? 64'd1 : 64'd0);
`endif
      tick();
    end
    b_iv = 1'b0;
    #1;
`ifdef ELASTIC_BUF_FALLTHROUGH_EN
    check_output("stream_end_ovalid", 64'(b_ov), 64'd0);
`else
    check_output("stream_last_data", 64'(b_dout), 64'h0117);
    tick();
`endif
    check_output("stream_end_count", 64'(b_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
